// File: rtl/ifetch_stage.sv
// ifetch_stage: program counter and IF/ID register in front of a combinational instruction ROM,
// with per-cycle redirect > flush > stall priority.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] imem_a,
    input  logic [31:0] imem_spo,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);
    logic [31:0] r_pc, r_id_instr, r_id_pc, r_id_pc4, r_fetch_count;
    logic        r_id_valid;
    logic [31:0] w_pc4;

    assign w_pc4       = r_pc + 32'd4;
    assign imem_a      = r_pc[13:2];
    assign pc          = r_pc;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc4      = r_id_pc4;
    assign id_valid    = r_id_valid;
    assign fetch_count = r_fetch_count;

    // id_pc/id_pc4 keep their last values across bubbles; only id_valid marks the slot empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 32'd0;
            r_id_pc4      <= 32'd0;
            r_id_valid    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (flush) begin
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
            if (!stall)
                r_pc <= w_pc4;
        end else if (!stall) begin
            r_pc          <= w_pc4;
            r_id_instr    <= imem_spo;
            r_id_pc       <= r_pc;
            r_id_pc4      <= w_pc4;
            r_id_valid    <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: vector table plus hand-written reset sequences against ifetch_stage,
// with a ROM model returning 32'h1000_0000 + word address.
module tb_ifetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] imem_a;
    logic [31:0] imem_spo;
    logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] pc, id_instr, id_pc, id_pc4, fetch_count;
    logic        id_valid;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        s, f, rv;
        logic [31:0] rpc;
        logic [31:0] epc, ei, eidpc, eidpc4;
        logic        ev;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    assign imem_spo = 32'h1000_0000 + {20'd0, imem_a};

    ifetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .imem_a(imem_a), .imem_spo(imem_spo),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .pc(pc), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc4(id_pc4), .id_valid(id_valid), .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        stall = v.s;
        flush = v.f;
        redirect_valid = v.rv;
        redirect_pc = v.rpc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d pc", idx), pc, e.epc);
        chk($sformatf("v%0d imem_a", idx), {20'd0, imem_a}, {20'd0, e.epc[13:2]});
        chk($sformatf("v%0d id_instr", idx), id_instr, e.ei);
        chk($sformatf("v%0d id_pc", idx), id_pc, e.eidpc);
        chk($sformatf("v%0d id_pc4", idx), id_pc4, e.eidpc4);
        chk($sformatf("v%0d id_valid", idx), {31'd0, id_valid}, {31'd0, e.ev});
        chk($sformatf("v%0d fetch_count", idx), fetch_count, e.ecnt);
    endtask

    initial begin
        // s f rv rpc | pc instr id_pc id_pc4 valid count
        vt.push_back('{0,0,0,32'h0,        32'h4,        32'h1000_0000, 32'h0,        32'h4,    1, 1});
        vt.push_back('{0,0,0,32'h0,        32'h8,        32'h1000_0001, 32'h4,        32'h8,    1, 2});
        vt.push_back('{0,0,0,32'h0,        32'hC,        32'h1000_0002, 32'h8,        32'hC,    1, 3});
        vt.push_back('{0,0,0,32'h0,        32'h10,       32'h1000_0003, 32'hC,        32'h10,   1, 4});
        vt.push_back('{0,1,0,32'h0,        32'h14,       NOP,           32'hC,        32'h10,   0, 4});
        vt.push_back('{0,0,1,32'h8,        32'h8,        NOP,           32'hC,        32'h10,   0, 4});
        vt.push_back('{1,0,0,32'h0,        32'h8,        NOP,           32'hC,        32'h10,   0, 4});
        vt.push_back('{1,0,0,32'h0,        32'h8,        NOP,           32'hC,        32'h10,   0, 4});
        vt.push_back('{1,0,0,32'h0,        32'h8,        NOP,           32'hC,        32'h10,   0, 4});
        vt.push_back('{0,0,0,32'h0,        32'hC,        32'h1000_0002, 32'h8,        32'hC,    1, 5});
        vt.push_back('{1,1,1,32'h103,      32'h100,      NOP,           32'h8,        32'hC,    0, 5});
        vt.push_back('{0,0,0,32'h0,        32'h104,      32'h1000_0040, 32'h100,      32'h104,  1, 6});
        vt.push_back('{0,0,1,32'h3FFC,     32'h3FFC,     NOP,           32'h100,      32'h104,  0, 6});
        vt.push_back('{0,0,0,32'h0,        32'h4000,     32'h1000_0FFF, 32'h3FFC,     32'h4000, 1, 7});
        vt.push_back('{0,0,0,32'h0,        32'h4004,     32'h1000_0000, 32'h4000,     32'h4004, 1, 8});
        vt.push_back('{0,0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,NOP,           32'h4000,     32'h4004, 0, 8});
        vt.push_back('{0,0,0,32'h0,        32'h0,        32'h1000_0FFF, 32'hFFFF_FFFC,32'h0,    1, 9});
        vt.push_back('{1,1,0,32'h0,        32'h0,        NOP,           32'hFFFF_FFFC,32'h0,    0, 9});
        vt.push_back('{1,0,0,32'h0,        32'h0,        NOP,           32'hFFFF_FFFC,32'h0,    0, 9});

        #12;
        chk("reset pc", pc, 32'h0);
        chk("reset imem_a", {20'd0, imem_a}, 32'h0);
        chk("reset id_instr", id_instr, NOP);
        chk("reset id_pc", id_pc, 32'h0);
        chk("reset id_pc4", id_pc4, 32'h0);
        chk("reset id_valid", {31'd0, id_valid}, 32'h0);
        chk("reset fetch_count", fetch_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) step(vt[i], i);

        // run from pc 0 to pc 0x20, then reset asynchronously between edges
        for (int k = 0; k < 8; k++)
            step('{0,0,0,32'h0, 32'h4*(k+1), 32'h1000_0000 + k, 32'h4*k, 32'h4*(k+1), 1, 10+k}, 100+k);
        chk("pre-reset pc", pc, 32'h20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async pc", pc, 32'h0);
        chk("async id_valid", {31'd0, id_valid}, 32'h0);
        chk("async fetch_count", fetch_count, 32'h0);
        chk("async id_instr", id_instr, NOP);
        #3;
        rst_n = 1'b1;
        step('{0,0,0,32'h0, 32'h4, 32'h1000_0000, 32'h0, 32'h4, 1, 1}, 200);

        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction fetch stage of the pipelined CPU. It sits directly upstream of the `imem` instruction ROM, which has a 12-bit word address `a` and an asynchronous 32-bit read port `spo`. The block holds the program counter and drives the ROM word address from it. It captures the returned instruction word into the IF/ID pipeline register, and handles stalls, flushes and branch/jump redirects from later stages.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset. Bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0000: word loaded into `id_instr` when a bubble is inserted.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `imem_a` output 12: word address to `imem.a`. Equals `pc[13:2]`, combinational from the PC register.
- `imem_spo` input 32: instruction word from `imem.spo`. Asynchronous read, valid in the same cycle as `imem_a`.
- `stall` input 1: hazard unit request to hold both the PC and IF/ID.
- `flush` input 1: insert a bubble into IF/ID.
- `redirect_valid` input 1: branch or jump taken. Load the PC from `redirect_pc`.
- `redirect_pc` input 32: target byte address. Bits [1:0] are ignored and treated as 0.
- `pc` output 32: current fetch byte address.
- `id_instr` output 32: IF/ID instruction word.
- `id_pc` output 32: byte address of `id_instr`.
- `id_pc4` output 32: `id_pc + 4`, modulo 2^32.
- `id_valid` output 1: IF/ID holds a real instruction (0 = bubble).
- `fetch_count` output 32: number of instructions accepted into IF/ID. Wraps.

## Operation
- Reset (`rst_n` = 0, asynchronous, effective immediately, including mid-operation):
  - `pc` = `RESET_PC`, so `imem_a` = `RESET_PC[13:2]`.
  - `id_instr` = `NOP_INSTR`.
  - `id_pc` = 0, `id_pc4` = 0.
  - `id_valid` = 0.
  - `fetch_count` = 0.
- Each rising edge, evaluated in strict priority order:
  1. `redirect_valid` = 1:
     - `pc` ← `{redirect_pc[31:2], 2'b00}`.
     - IF/ID ← bubble: `id_instr` = `NOP_INSTR`, `id_valid` = 0; `id_pc` and `id_pc4` hold their previous values.
     - Overrides both `stall` and `flush`.
  2. `flush` = 1:
     - IF/ID ← bubble.
     - `pc` ← `pc + 4` if `stall` = 0, otherwise `pc` holds.
  3. `stall` = 1: `pc` and all IF/ID fields hold.
  4. Normal:
     - IF/ID ← {`imem_spo`, `pc`, `pc + 4`, `id_valid` = 1}.
     - `pc` ← `pc + 4`.
     - `fetch_count` increments.
- `fetch_count` increments only in case 4.
- PC arithmetic is 32-bit unsigned, so `pc + 4` from 32'hFFFF_FFFC yields 0.
- `imem_a` uses only `pc[13:2]`, so the word address wraps from 12'hFFF to 12'h000 every 16 KiB. Upper PC bits are not checked.
- No state machine beyond the two registers. Control is purely per-cycle priority.

## Timing
- Fetch latency:
  - The PC value is presented on `imem_a` in cycle N.
  - The instruction appears on `id_instr` after edge N+1, i.e. one cycle.
  - Throughput is one instruction per cycle when unstalled.
- Redirect penalty:
  - The target address appears on `imem_a` the cycle after `redirect_valid` is sampled.
  - IF/ID shows one bubble, then the target instruction appears one cycle later.
- Stall:
  - `imem_a` stays constant while `stall` = 1.
  - The ROM output is re-sampled when the stall releases; no skid buffer is needed because the ROM is combinational.
- First edge after reset deassertion: `id_instr` = `mem[RESET_PC[13:2]]`, `id_valid` = 1, `pc` = `RESET_PC + 4`.

## Test plan
- Reset and sequential fetch:
  - Stimulus: ROM word k = 32'h1000_0000 + k; release `rst_n`; run 4 cycles.
  - Required: `id_instr` = 1000_0000, 1000_0001, 1000_0002, 1000_0003; `id_pc` = 0, 4, 8, C; `fetch_count` = 4.
- Stall:
  - Stimulus: with `pc` = 8, assert `stall` for 3 cycles.
  - Required: `imem_a` = 2 and `id_instr`/`id_pc` frozen for all 3 cycles; after release, the next `id_instr` = 1000_0002; `fetch_count` unchanged during the stall.
- Redirect with simultaneous stall and flush:
  - Stimulus: `redirect_pc` = 32'h0000_0103 with `redirect_valid` = `stall` = `flush` = 1.
  - Required: next `pc` = 0000_0100; `id_valid` = 0; one cycle later `id_instr` = 1000_0040 and `id_pc` = 100.
- Flush only:
  - Stimulus: assert `flush` for 1 cycle at `pc` = 0x10.
  - Required: `id_valid` = 0 and `id_instr` = `NOP_INSTR`; `pc` advances to 0x14.
- Wrap-around:
  - Stimulus: redirect to 32'h0000_3FFC, then run 2 cycles.
  - Required: `imem_a` = FFF, then 000; `id_pc4` = 0000_4000.
  - Stimulus: redirect to FFFF_FFFC.
  - Required: next `pc` = 0.
- Asynchronous reset mid-stream:
  - Stimulus: drop `rst_n` between clock edges at `pc` = 0x20.
  - Required: `pc`, `id_valid` and `fetch_count` clear immediately, without waiting for a clock edge.
